color_fsm_initiator: RTL and testbench

- Initiator/checker for the two-state Blue/Red Mealy colour FSM (the responder).
- Accepts target-colour requests on a valid/ready interface and converts each into the 2-bit `in` command the responder expects.
- Checks the responder's combinational 2-bit `out` reply in the same cycle and keeps a mirror copy of the responder state.
- On a mismatch, resynchronises the mirror from the responder's reply; on repeated failure, latches a sticky fault.

---
 rtl/color_fsm_initiator.sv | 177 +++++++++++++++++
 tb/tb_color_fsm_initiator.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/color_fsm_initiator.sv
// Initiator/checker for the Blue/Red colour responder: turns colour requests into
// responder commands, checks replies and mirrors its state. Optional: COLOR_INIT_STATS_EN.
module color_fsm_initiator #(
  parameter int CNT_W     = 8,
  parameter int RETRY_MAX = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_color,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_err,
  output logic [1:0]       fsm_in,
  input  logic [1:0]       fsm_out,
  output logic             mirror_color,
  output logic             busy,
  output logic             fault,
  output logic [CNT_W-1:0] err_cnt
`ifdef COLOR_INIT_STATS_EN
  ,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic             resync_pulse
`endif
);

  // state  | meaning
  // IDLE   | ready for a request, responder held with idle command
  // ISSUE  | one cycle driving the move/hold command, reply checked at its end
  // RESYNC | reply was wrong; probe with in=1 and adopt the reported colour
  // RESP   | completion presented until rsp_ready
  // FAULT  | resync exhausted; only rst leaves
  typedef enum logic [2:0] {IDLE, ISSUE, RESYNC, RESP, FAULT} state_t;

  localparam int RW = $clog2(RETRY_MAX + 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);

  state_t           state_q, state_d;
  logic             target_q, target_d;
  logic             mirror_q, mirror_d;
  logic             rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [1:0]       fsm_in_q, fsm_in_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             busy_q, busy_d;
  logic             fault_q, fault_d;
  logic [1:0]       exp_out;
`ifdef COLOR_INIT_STATS_EN
  logic [CNT_W-1:0] toggle_q, toggle_d;
  logic             pulse_q, pulse_d;
`endif

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    mirror_d  = mirror_q;
    rsp_err_d = rsp_err_q;
    err_cnt_d = err_cnt_q;
    retry_d   = retry_q;
`ifdef COLOR_INIT_STATS_EN
    toggle_d  = toggle_q;
    pulse_d   = 1'b0;
`endif
    // Both legal commands report the resulting colour: 1 = Blue, 2 = Red.
    exp_out = target_q ? 2'h2 : 2'h1;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          target_d = req_color;
          if (!req_color && !mirror_q) begin
            state_d   = RESP;
            rsp_err_d = 1'b0;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (fsm_out == exp_out) begin
          mirror_d  = target_q;
          rsp_err_d = 1'b0;
          state_d   = RESP;
`ifdef COLOR_INIT_STATS_EN
          if (target_q != mirror_q && toggle_q != '1) toggle_d = toggle_q + CNT_W'(1);
`endif
        end else begin
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
          retry_d = '0;
          state_d = RESYNC;
        end
      end
      RESYNC: begin
        if (fsm_out == 2'h1 || fsm_out == 2'h2) begin
          mirror_d  = fsm_out[1];
          rsp_err_d = 1'b1;
          state_d   = RESP;
`ifdef COLOR_INIT_STATS_EN
          pulse_d   = 1'b1;
`endif
        end else begin
          retry_d = retry_q + RW'(1);
          if (retry_d == RETRY_LIM) state_d = FAULT;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered yet in phase.
    fsm_in_d = 2'h2;
    if (state_d == ISSUE)       fsm_in_d = (target_d != mirror_d) ? 2'h1 : 2'h0;
    else if (state_d == RESYNC) fsm_in_d = 2'h1;
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
    fault_d     = (state_d == FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      target_q    <= 1'b1;
      mirror_q    <= 1'b1;
      rsp_err_q   <= 1'b0;
      err_cnt_q   <= '0;
      retry_q     <= '0;
      fsm_in_q    <= 2'h2;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      fault_q     <= 1'b0;
`ifdef COLOR_INIT_STATS_EN
      toggle_q    <= '0;
      pulse_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      mirror_q    <= mirror_d;
      rsp_err_q   <= rsp_err_d;
      err_cnt_q   <= err_cnt_d;
      retry_q     <= retry_d;
      fsm_in_q    <= fsm_in_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      fault_q     <= fault_d;
`ifdef COLOR_INIT_STATS_EN
      toggle_q    <= toggle_d;
      pulse_q     <= pulse_d;
`endif
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_err      = rsp_err_q;
  assign fsm_in       = fsm_in_q;
  assign mirror_color = mirror_q;
  assign busy         = busy_q;
  assign fault        = fault_q;
  assign err_cnt      = err_cnt_q;
`ifdef COLOR_INIT_STATS_EN
  assign toggle_cnt   = toggle_q;
  assign resync_pulse = pulse_q;
`endif

endmodule

// File: tb/tb_color_fsm_initiator.sv
// Bench for color_fsm_initiator: directed and randomized requests against a behavioural
// responder, with a transaction-level model predicting latency, error flag and counters.
module tb_color_fsm_initiator;
  localparam int CNT_W     = 8;
  localparam int RETRY_MAX = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_color = 1'b0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic             rsp_err;
  logic [1:0]       fsm_in;
  logic [1:0]       fsm_out;
  logic             mirror_color;
  logic             busy;
  logic             fault;
  logic [CNT_W-1:0] err_cnt;
`ifdef COLOR_INIT_STATS_EN
  logic [CNT_W-1:0] toggle_cnt;
  logic             resync_pulse;
`endif

  color_fsm_initiator #(.CNT_W(CNT_W), .RETRY_MAX(RETRY_MAX)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_color(req_color),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err),
    .fsm_in(fsm_in), .fsm_out(fsm_out), .mirror_color(mirror_color),
    .busy(busy), .fault(fault), .err_cnt(err_cnt)
`ifdef COLOR_INIT_STATS_EN
    , .toggle_cnt(toggle_cnt), .resync_pulse(resync_pulse)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Responder: returns {next_state, out}; out always reports the resulting colour.
  function automatic logic [2:0] resp_step(input logic s, input logic [1:0] cmd);
    if (cmd == 2'h1) return s ? {1'b0, 2'h1} : {1'b1, 2'h2};
    return {s, s ? 2'h2 : 2'h1};
  endfunction

  logic       resp_s;
  logic [2:0] rstep;
  logic       corrupt_req = 1'b0;
  logic       corrupt_val = 1'b0;
  logic       force_en = 1'b0;
  logic [1:0] force_val = 2'h0;

  always_comb begin
    rstep   = resp_step(resp_s, fsm_in);
    fsm_out = force_en ? force_val : rstep[1:0];
  end

  always @(posedge clk or posedge rst) begin
    if (rst)              resp_s <= 1'b1;
    else if (corrupt_req) resp_s <= corrupt_val;
    else                  resp_s <= rstep[2];
  end

  // Transaction-level reference state
  logic       m_mirror = 1'b1;
  logic       m_resp = 1'b1;
  logic [7:0] m_err = 8'h0;
  logic [7:0] m_tog = 8'h0;
  logic       m_fault = 1'b0;
  logic       m_err_exp = 1'b0;

  task automatic model_req(input logic t, output int lat, output logic [1:0] cmd);
    logic [2:0] r;
    logic [1:0] o;
    m_fault = 1'b0;
    if (!t && !m_mirror) begin
      lat = 1; cmd = 2'h2; m_err_exp = 1'b0;
      return;
    end
    cmd = (t != m_mirror) ? 2'h1 : 2'h0;
    r = resp_step(m_resp, cmd);
    m_resp = r[2];
    o = force_en ? force_val : r[1:0];
    if (o == (t ? 2'h2 : 2'h1)) begin
      if (t != m_mirror && m_tog != 8'hff) m_tog++;
      m_mirror = t; lat = 2; m_err_exp = 1'b0;
    end else begin
      if (m_err != 8'hff) m_err++;
      m_err_exp = 1'b1; m_fault = 1'b1; lat = 2 + RETRY_MAX;
      for (int k = 0; k < RETRY_MAX; k++) begin
        r = resp_step(m_resp, 2'h1);
        m_resp = r[2];
        o = force_en ? force_val : r[1:0];
        if (o == 2'h1 || o == 2'h2) begin
          m_mirror = o[1]; m_fault = 1'b0; lat = 3 + k;
          break;
        end
      end
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic start_req(input logic t);
    int lat, idx;
    logic [1:0] cmd;
    req_valid = 1'b1; req_color = t;
    chk("req_ready_idle", req_ready, 1);
    model_req(t, lat, cmd);
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    idx = 1;
    chk("fsm_in_issue", fsm_in, cmd);
    chk("busy", busy, 1);
    while (!rsp_valid && !fault && idx < 20) begin
      @(negedge clk);
      idx++;
      if (!rsp_valid && !fault) chk("fsm_in_resync", fsm_in, 2'h1);
    end
    chk("latency", idx, lat);
    chk("fault", fault, m_fault);
    chk("mirror", mirror_color, m_mirror);
    chk("err_cnt", err_cnt, m_err);
`ifdef COLOR_INIT_STATS_EN
    chk("toggle_cnt", toggle_cnt, m_tog);
`endif
    if (!m_fault) begin
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_err", rsp_err, m_err_exp);
`ifdef COLOR_INIT_STATS_EN
      chk("resync_pulse", resync_pulse, m_err_exp);
`endif
    end
  endtask

  task automatic finish_rsp(input int hold, input bit overlap);
    repeat (hold) begin
      @(negedge clk);
      chk("rsp_hold_valid", rsp_valid, 1);
      chk("rsp_hold_err", rsp_err, m_err_exp);
    end
    rsp_ready = 1'b1;
    if (overlap) begin req_valid = 1'b1; req_color = ~m_mirror; end
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_done_valid", rsp_valid, 0);
    chk("rsp_done_busy", busy, 0);
    chk("rsp_done_ready", req_ready, 1);
  endtask

  task automatic corrupt(input logic v);
    corrupt_val = v; corrupt_req = 1'b1;
    @(posedge clk); @(negedge clk);
    corrupt_req = 1'b0;
    m_resp = v;
  endtask

  task automatic apply_reset();
    #2 rst = 1'b1;
    req_valid = 1'b0; rsp_ready = 1'b0; force_en = 1'b0;
    m_mirror = 1'b1; m_resp = 1'b1; m_err = 8'h0; m_tog = 8'h0; m_fault = 1'b0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mirror", mirror_color, 1);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_fault", fault, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_fsm_in", fsm_in, 2'h2);
`ifdef COLOR_INIT_STATS_EN
    chk("rst_toggle_cnt", toggle_cnt, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    apply_reset();
    @(negedge clk);

    start_req(1'b0); finish_rsp(0, 0);     // Red -> Blue
    start_req(1'b0); finish_rsp(1, 0);     // Blue no-op
    start_req(1'b1); finish_rsp(0, 0);     // Blue -> Red
    start_req(1'b1); finish_rsp(2, 0);     // Red hold
    corrupt(1'b0);                         // responder Blue, mirror Red
    start_req(1'b1); finish_rsp(1, 1);     // mismatch + resync, then overlap
    start_req(req_color); finish_rsp(0, 0);

    for (int n = 0; n < 60; n++) begin
      int mode;
      mode = $urandom_range(0, 9);
      if (mode < 2) corrupt(1'($urandom));
      if (mode == 2) begin
        force_en = 1'b1;
        force_val = ($urandom_range(0, 1) == 0) ? 2'h1 : 2'h2;
      end
      start_req(1'($urandom));
      force_en = 1'b0;
      finish_rsp($urandom_range(0, 3), 0);
    end

    // Reset while a completion is pending
    corrupt(~m_mirror);
    start_req(1'b1);
    repeat (2) @(negedge clk);
    apply_reset();
    @(negedge clk);

    // Responder reply stuck at 3: resync exhausts into FAULT
    force_en = 1'b1; force_val = 2'h3;
    start_req(1'b1);
    req_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("fault_sticky", fault, 1);
      chk("fault_req_ready", req_ready, 0);
      chk("fault_rsp_valid", rsp_valid, 0);
      chk("fault_fsm_in", fsm_in, 2'h2);
      chk("fault_err_cnt", err_cnt, 1);
    end
    apply_reset();
    @(negedge clk);
    start_req(1'b0); finish_rsp(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
